// File: rtl/x_stream_gen_if.sv
// Handshake/stream bundle for x_stream_gen: the start/data/len request and the
// x/busy/done/S status the transmitter returns.
interface x_stream_gen_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic [LEN_W-1:0] len;
  logic             x;
  logic             busy;
  logic             done;
  logic [2:0]       S;

  modport master (
    output start, data, len,
    input  x, busy, done, S
  );

  modport slave (
    input  start, data, len,
    output x, busy, done, S
  );
endinterface

// File: rtl/x_stream_gen.sv
// Serial stimulus transmitter: captures a pattern on start and shifts its low
// len bits out MSB-first on x. Optional trailing even-parity bit under PARITY_EN.
module x_stream_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  x_stream_gen_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    SHIFT  = 3'b001,
    PARITY = 3'b010,
    DONE   = 3'b011
  } state_t;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] sh_q;
  logic [LEN_W-1:0] cnt_q;
  logic             x_q;
  logic             busy_q;
  logic             done_q;
`ifdef PARITY_EN
  logic             par_q;
`endif

  logic [LEN_W-1:0] len_d;
  logic [WIDTH-1:0] load_d;

  // Left-align the selected bits so the shifter always emits from the MSB.
  always_comb begin
    len_d = bus.len;
    if (bus.len == '0 || bus.len > WIDTH_L) begin
      len_d = WIDTH_L;
    end
    load_d = bus.data << (WIDTH_L - len_d);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          x_q    <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.start) begin
            state_q <= SHIFT;
            x_q     <= load_d[WIDTH-1];
            busy_q  <= 1'b1;
            sh_q    <= load_d << 1;
            cnt_q   <= len_d - 1'b1;
`ifdef PARITY_EN
            par_q   <= load_d[WIDTH-1];
`endif
          end
        end

        SHIFT: begin
          // cnt_q counts bits still to emit after the one currently on x.
          if (cnt_q == '0) begin
`ifdef PARITY_EN
            state_q <= PARITY;
            x_q     <= par_q;
            busy_q  <= 1'b1;
`else
            state_q <= DONE;
            x_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`endif
          end else begin
            x_q   <= sh_q[WIDTH-1];
            sh_q  <= sh_q << 1;
            cnt_q <= cnt_q - 1'b1;
`ifdef PARITY_EN
            par_q <= par_q ^ sh_q[WIDTH-1];
`endif
          end
        end

`ifdef PARITY_EN
        PARITY: begin
          state_q <= DONE;
          x_q     <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
`endif

        DONE: begin
          state_q <= IDLE;
          x_q     <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          x_q     <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x    = x_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.S    = state_q;

endmodule

// File: doc/x_stream_gen.md
Name: x_stream_gen

Overview:
Serial stimulus transmitter that produces the single-bit `x` stream consumed by the team's clocked sequence-detector machines.
- Loads a parallel pattern on a start pulse and shifts it out MSB-first, one bit per CLK.
- Exposes its own 3-bit state on `S`.
- Sits upstream of a detector's `x` input, in place of hand-timed testbench assignments.

Parameters:
WIDTH, 8, maximum pattern length in bits.
LEN_W, 4, width of the `len` port; 2**LEN_W must exceed WIDTH.

Ports:
CLK    input   1        rising-edge clock, the only clock.
RESET  input   1        asynchronous, active-low reset (0 = reset asserted).
start  input   1        begin transmission; sampled only in IDLE.
data   input   WIDTH    pattern; the low `len` bits are sent.
len    input   LEN_W    number of bits to send; 0 or >WIDTH means WIDTH.
x      output  1        serial bit stream, registered.
busy   output  1        high while bits are being emitted.
done   output  1        one-cycle pulse after the last bit.
S      output  3        current state encoding.

Behaviour:
- Reset (RESET=0, asynchronous, any state): S=IDLE, x=0, busy=0, done=0, shift register and counter cleared. Outputs hold these values until the first rising edge after RESET returns to 1.
- States:
  - IDLE=3'b000
  - SHIFT=3'b001
  - PARITY=3'b010 (only with the optional feature)
  - DONE=3'b011
  - 3'b1xx unused; these go to IDLE on the next edge with x=0.
- IDLE, start=0: remain; x=0, busy=0, done=0.
- IDLE, start=1 at an edge:
  - Capture data and effective length N (N = len, or WIDTH if len==0 or len>WIDTH).
  - Go to SHIFT, with x=data[N-1] and busy=1 from that same edge.
- SHIFT:
  - Each edge advances one bit. x takes data[N-2], data[N-3], …, data[0].
  - Each bit is held exactly one clock period.
  - Total SHIFT residency is N cycles.
- After the bit data[0] has been held one cycle: go to DONE (or to PARITY if the feature is enabled).
- DONE: exactly one cycle with x=0, busy=0, done=1; then unconditionally IDLE.
- Latency: the first bit appears on x at the start edge. done asserts N cycles after the start edge (N+1 with parity).
- Handshake:
  - start is ignored in SHIFT, PARITY and DONE. No queuing.
  - A start held high through DONE causes a new transfer at the first IDLE edge. Minimum gap between transfers is 1 idle cycle.
- data and len may change freely after the capture edge; the captured copy is used.
- N=1: one SHIFT cycle, then DONE.
- Reset mid-transfer: the transfer aborts immediately, x=0, and no done pulse is produced.
- busy is 1 exactly in SHIFT and PARITY. done is 1 exactly in DONE.

Optional Feature:
Macro PARITY_EN.
- Defined:
  - After the last data bit, the block enters PARITY for one cycle with x equal to the XOR of the N transmitted bits (even parity) and busy=1.
  - It then enters DONE.
- Undefined: the PARITY state is not generated; SHIFT goes directly to DONE, and 3'b010 is treated as unused.

Test Plan:
- Reset: hold RESET=0 for 7 ns mid-cycle, then release → x=0, busy=0, done=0, S=000 asynchronously, before any edge.
- Basic transfer: data=8'hA5, len=8, start pulsed 1 cycle.
  - x over 8 cycles = 1,0,1,0,0,1,0,1.
  - busy=1 for exactly 8 cycles.
  - done=1 on cycle 9, S=011; IDLE on cycle 10.
- Short length and clamp:
  - data=8'h06, len=3 → x=1,1,0, done on cycle 4.
  - len=0 and len=15 each → 8 bits sent.
- start ignored while busy: pulse start on SHIFT cycle 4 with a different data value → the original stream is unchanged, and only one done pulse occurs.
- Reset mid-transfer: RESET=0 during SHIFT cycle 3 of 8'hFF → x drops to 0 immediately, no done pulse; a later start sends a complete fresh 8 bits.
- PARITY_EN build: data=8'h07, len=3 → x=1,1,1, then parity bit 1; busy=1 for 4 cycles; done on cycle 5. With data=8'h03, len=3, the parity bit is 0.
